// File: rtl/hilo_divider.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_divider
//  Description : Sequential Hi/Lo unit. Restoring unsigned divide, one
//                quotient bit per clock, MSB first (Hi = remainder,
//                Lo = quotient). Divide-by-zero completes one edge after
//                start with Hi = dividend, Lo = all ones, div_zero = 1.
//                Optional shift-add multiply when HILO_MULT_EN is defined
//                (Hi/Lo = upper/lower product halves, same latency).
//  Macro       : HILO_MULT_EN (undefined: is_mult ignored, divide only)
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_mult,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    // Partial remainder (divide) or running product upper half plus carry (multiply)
    logic [WIDTH:0]   r_rem;
    // Dividend shifting out / quotient shifting in (divide), multiplier / product low half (multiply)
    logic [WIDTH-1:0] r_quo;
    // Divisor (divide) or multiplicand (multiply)
    logic [WIDTH-1:0] r_div;
    // Current operation is a divide by zero
    logic             r_dz;

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_div_rem;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic             w_start_mult;
    logic             w_start_dz;

    // Restoring divide step: shift in next dividend bit, subtract if it fits.
    // The extra remainder bit keeps the shifted value exact when opA is all ones.
    assign w_shift   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_div});
    assign w_sub     = w_shift - {1'b0, r_div};
    assign w_div_rem = w_ge ? w_sub : w_shift;
    assign w_div_quo = {r_quo[WIDTH-2:0], w_ge};

`ifdef HILO_MULT_EN
    logic             r_mult;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_mul_rem;
    logic [WIDTH-1:0] w_mul_quo;

    // Shift-add multiply step: add multiplicand when multiplier LSB is set,
    // then shift the {upper, lower} product pair right by one.
    assign w_sum     = {1'b0, r_rem[WIDTH-1:0]} + (r_quo[0] ? {1'b0, r_div} : {(WIDTH+1){1'b0}});
    assign w_mul_rem = {1'b0, w_sum[WIDTH:1]};
    assign w_mul_quo = {w_sum[0], r_quo[WIDTH-1:1]};

    assign w_rem_nxt    = r_mult ? w_mul_rem : w_div_rem;
    assign w_quo_nxt    = r_mult ? w_mul_quo : w_div_quo;
    assign w_start_mult = is_mult;

    // Operation type latched at start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mult <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_mult <= is_mult;
        end
    end
`else
    logic w_unused_is_mult;

    assign w_unused_is_mult = is_mult;
    assign w_rem_nxt        = w_div_rem;
    assign w_quo_nxt        = w_div_quo;
    assign w_start_mult     = 1'b0;
`endif

    assign w_start_dz = !w_start_mult && (opB == {WIDTH{1'b0}});

    // Control FSM, iteration datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_dz     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            HiOut    <= '0;
            LoOut    <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt <= CW'(WIDTH);
                        r_rem <= '0;
                        r_dz  <= w_start_dz;
                        busy  <= 1'b1;
                        if (w_start_mult) begin
                            r_quo <= opB;
                            r_div <= opA;
                        end else begin
                            r_quo <= opA;
                            r_div <= opB;
                        end
                        r_state <= w_start_dz ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (r_dz) begin
                        // r_quo still holds the untouched dividend
                        HiOut    <= r_quo;
                        LoOut    <= {WIDTH{1'b1}};
                        div_zero <= 1'b1;
                    end else begin
                        HiOut    <= r_rem[WIDTH-1:0];
                        LoOut    <= r_quo;
                        div_zero <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_divider
//  Description : Self-checking bench for hilo_divider (WIDTH = 32).
//                Table of directed operations applied back-to-back, plus
//                hand sequences for busy-ignore and reset mid-operation.
//                Expectations follow HILO_MULT_EN when it is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_divider;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         is_mult;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] HiOut;
    logic [W-1:0] LoOut;

    int checks;
    int failures;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    hilo_divider #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .is_mult  (is_mult),
        .opA      (opA),
        .opB      (opB),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .HiOut    (HiOut),
        .LoOut    (LoOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Start is sampled at the next rising edge ("edge 0"); latency counts edges to done.
    task automatic run_op(input vec_t v, input string name);
        int  lat;
        bit  got;
        start   = 1'b1;
        opA     = v.a;
        opB     = v.b;
        is_mult = v.m;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, " busy_after_start"}, 64'(busy), 64'(1));
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            chk({name, " timeout"}, 64'(0), 64'(1));
        end else begin
            chk({name, " latency"}, 64'(lat), 64'(v.lat));
            chk({name, " HiOut"}, 64'(HiOut), 64'(v.hi));
            chk({name, " LoOut"}, 64'(LoOut), 64'(v.lo));
            chk({name, " div_zero"}, 64'(div_zero), 64'(v.dz));
            chk({name, " busy_at_done"}, 64'(busy), 64'(0));
        end
    endtask

    initial begin
        int n_done;
        int first_lat;
        logic [W-1:0] hold_hi;
        logic [W-1:0] hold_lo;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        is_mult  = 1'b0;
        opA      = '0;
        opB      = '0;

        //           a             b     m     hi            lo            dz   lat
        vecs[0] = '{32'd100,      32'd7, 1'b0, 32'd2,        32'd14,       1'b0, 33};
        vecs[1] = '{32'h12345678, 32'd0, 1'b0, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1};
        vecs[2] = '{32'd9,        32'd3, 1'b0, 32'd0,        32'd3,        1'b0, 33};
        vecs[3] = '{32'hFFFFFFFF, 32'd1, 1'b0, 32'd0,        32'hFFFFFFFF, 1'b0, 33};
        vecs[4] = '{32'd0,        32'd5, 1'b0, 32'd0,        32'd0,        1'b0, 33};
        vecs[5] = '{32'd5,        32'd9, 1'b0, 32'd5,        32'd0,        1'b0, 33};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0,  32'd1,        1'b0, 33};
        vecs[7] = '{32'h80000000, 32'd3, 1'b0, 32'd2,        32'h2AAAAAAA, 1'b0, 33};
`ifdef HILO_MULT_EN
        vecs[8] = '{32'hFFFFFFFF, 32'd2,    1'b1, 32'd1, 32'hFFFFFFFE, 1'b0, 33};
        vecs[9] = '{32'd1000,     32'd1000, 1'b1, 32'd0, 32'h000F4240, 1'b0, 33};
`else
        vecs[8] = '{32'hFFFFFFFF, 32'd2,    1'b1, 32'd1, 32'h7FFFFFFF, 1'b0, 33};
        vecs[9] = '{32'h00000055, 32'd0,    1'b1, 32'h55, 32'hFFFFFFFF, 1'b1, 1};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset div_zero", 64'(div_zero), 64'(0));
        chk("reset HiOut", 64'(HiOut), 64'(0));
        chk("reset LoOut", 64'(LoOut), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle no busy", 64'(busy), 64'(0));
        chk("idle no done", 64'(done), 64'(0));

        // Table: each operation starts in the IDLE cycle right after the previous done
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Done is a single-cycle pulse and results hold afterwards
        hold_hi = HiOut;
        hold_lo = LoOut;
        repeat (4) @(posedge clk);
        #1;
        chk("done pulse width", 64'(done), 64'(0));
        chk("hold HiOut", 64'(HiOut), 64'(hold_hi));
        chk("hold LoOut", 64'(LoOut), 64'(hold_lo));

        // Start while busy is ignored: 100/7, re-pulse 50/5 at edge 10
        start = 1'b1; opA = 32'd100; opB = 32'd7; is_mult = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0;
        first_lat = 0;
        for (int e = 1; e <= 60; e++) begin
            if (e == 10) begin
                start = 1'b1; opA = 32'd50; opB = 32'd5;
            end
            @(posedge clk); #1;
            if (e == 10) start = 1'b0;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    first_lat = e;
                    chk("busy-ignore HiOut", 64'(HiOut), 64'(2));
                    chk("busy-ignore LoOut", 64'(LoOut), 64'(14));
                end
            end
        end
        chk("busy-ignore done count", 64'(n_done), 64'(1));
        chk("busy-ignore latency", 64'(first_lat), 64'(33));

        // Reset in the middle of an operation
        start = 1'b1; opA = 32'd100; opB = 32'd7; is_mult = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("pre-reset busy", 64'(busy), 64'(1));
        chk("pre-reset HiOut held", 64'(HiOut), 64'(2));
        rst_n = 1'b0;
        #1;
        chk("async reset busy", 64'(busy), 64'(0));
        chk("async reset HiOut", 64'(HiOut), 64'(0));
        chk("async reset LoOut", 64'(LoOut), 64'(0));
        chk("async reset done", 64'(done), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int e = 0; e < 45; e++) begin
            @(posedge clk); #1;
            if (done || busy) n_done++;
        end
        chk("no activity after reset", 64'(n_done), 64'(0));

        // Operation after reset still works
        run_op(vecs[0], "post-reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hilo_divider.md
HILO_DIVIDER -- requirements
Module: hilo_divider

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request new operation; sampled only in IDLE.
REQ-005 is_mult  input  1  1 = multiply, 0 = divide; sampled with start.
REQ-006 opA  input  WIDTH  dividend / multiplicand, unsigned.
REQ-007 opB  input  WIDTH  divisor / multiplier, unsigned.
REQ-008 busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-009 done  output  1  one-cycle pulse; HiOut/LoOut updated on the same edge.
REQ-010 div_zero  output  1  registered flag: last completed divide had opB == 0.
REQ-011 HiOut  output  WIDTH  Hi register: remainder (div) or product upper half (mult).
REQ-012 LoOut  output  WIDTH  Lo register: quotient (div) or product lower half (mult).

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-014 IDLE with start=1 SHALL latch opA, opB, is_mult, load cycle counter with WIDTH, go to RUN; busy rises the next cycle.
REQ-015 IDLE with start=0 SHALL stay in IDLE; busy=0, done=0.
REQ-016 start while busy=1 SHALL be ignored, with no effect on operands, counter or results.
REQ-017 Divide SHALL be restoring, one quotient bit per cycle, MSB first, using a WIDTH+1-bit partial remainder to avoid overflow at opA = 2^WIDTH-1.
REQ-018 RUN SHALL decrement the counter each cycle; on counter reaching 1 the next state SHALL be DONE.
REQ-019 DONE SHALL last exactly one cycle: done=1, HiOut/LoOut/div_zero written, then IDLE.
REQ-020 Latency: start sampled at edge N gives done=1 in the cycle after edge N+WIDTH+1 (edge 33 for WIDTH=32).
REQ-021 Divide with opB == 0 SHALL skip RUN: IDLE -> DONE, done one edge after start; HiOut=opA, LoOut=all ones, div_zero=1.
REQ-022 Any completed operation other than divide-by-zero SHALL clear div_zero.
REQ-023 HiOut/LoOut SHALL hold their value between completions; intermediate values never appear on them.
REQ-024 A new start may be accepted in the IDLE cycle immediately after DONE (back-to-back, no gap cycle).
REQ-025 Results SHALL satisfy LoOut*opB + HiOut == opA with HiOut < opB for every divide where opB != 0.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, clear the counter and operand registers, and set busy=0, done=0, div_zero=0, HiOut=0, LoOut=0.
REQ-027 Reset asserted during RUN or DONE SHALL abort the operation, with no done pulse and no partial result kept.
REQ-028 Release of rst_n SHALL not start an operation unless start=1 is sampled in IDLE afterwards.

Configuration
REQ-029 Macro HILO_MULT_EN: when defined, is_mult=1 SHALL run a shift-add multiply in the same RUN/DONE sequence, with WIDTH-cycle latency identical to divide; HiOut gets product[2*WIDTH-1:WIDTH], LoOut gets product[WIDTH-1:0], div_zero=0.
REQ-030 When HILO_MULT_EN is undefined, the is_mult port SHALL remain present but be ignored; every operation SHALL be a divide and no multiply datapath SHALL be synthesized.

Verification
REQ-031 Divide: opA=100, opB=7, start pulse at edge 0 -> done at edge 33, HiOut=2, LoOut=14, div_zero=0.
REQ-032 Divide by zero: opA=0x12345678, opB=0 -> done at edge 1, HiOut=0x12345678, LoOut=0xFFFFFFFF, div_zero=1; the next 9/3 clears div_zero with HiOut=0, LoOut=3.
REQ-033 Busy ignore: start 100/7, re-pulse start with 50/5 at edge 10 -> single done at edge 33 with 2/14; no second done.
REQ-034 Reset mid-op: start 100/7, rst_n low at edge 15 -> busy=0 and HiOut=LoOut=0 immediately; no done pulse after release.
REQ-035 Boundary: opA=0xFFFFFFFF, opB=1 -> HiOut=0, LoOut=0xFFFFFFFF; back-to-back start the cycle after done is accepted.
REQ-036 HILO_MULT_EN defined: is_mult=1, opA=0xFFFFFFFF, opB=2 -> done at edge 33, HiOut=1, LoOut=0xFFFFFFFE; undefined: the same stimulus performs a divide, giving HiOut=1, LoOut=0x7FFFFFFF.
